// File: rtl/eep_arb.sv
// ============================================================================
// eep_arb : round-robin sequencer for the off-chip trim EEPROM (read, timed
//           write with charge pump, recovery gap). Optional macro: EEP_WR_PROT_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module eep_arb #(
    parameter int RD_CYCLES    = 4,
    parameter int CP_CYCLES    = 2400000,
    parameter int RECOV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [1:0]  wr,
    input  logic [1:0]  addr0,
    input  logic [1:0]  addr1,
    input  logic [13:0] wdata0,
    input  logic [13:0] wdata1,
    input  logic [13:0] eep_rd_data,
`ifdef EEP_WR_PROT_EN
    input  logic        wr_unlock,
    output logic        wr_err,
`endif
    output logic [1:0]  done,
    output logic [13:0] rdata,
    output logic        busy,
    output logic        eep_cs_n,
    output logic        eep_r_w_n,
    output logic [1:0]  eep_addr,
    output logic [13:0] eep_wdata,
    output logic        chrg_pmp_en
);

    localparam int MAX_RD_CP = (RD_CYCLES > CP_CYCLES) ? RD_CYCLES : CP_CYCLES;
    localparam int MAX_CYC   = (MAX_RD_CP > RECOV_CYCLES) ? MAX_RD_CP : RECOV_CYCLES;
    localparam int CNT_W     = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        WR    = 2'd2,
        RECOV = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              last_gnt;
    logic              win;
    logic              sel_wr;
    logic [1:0]        sel_addr;
    logic [13:0]       sel_wdata;

    // A lone requester wins; on contention the one not granted last time wins.
    always_comb begin
        win = 1'b0;
        if (req == 2'b10) begin
            win = 1'b1;
        end else if (req == 2'b11) begin
            win = ~last_gnt;
        end
    end

    assign sel_wr    = win ? wr[1]  : wr[0];
    assign sel_addr  = win ? addr1  : addr0;
    assign sel_wdata = win ? wdata1 : wdata0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            last_gnt    <= 1'b1;
            done        <= 2'b00;
            rdata       <= '0;
            busy        <= 1'b0;
            eep_cs_n    <= 1'b1;
            eep_r_w_n   <= 1'b1;
            eep_addr    <= '0;
            eep_wdata   <= '0;
            chrg_pmp_en <= 1'b0;
`ifdef EEP_WR_PROT_EN
            wr_err      <= 1'b0;
`endif
        end else begin
            done <= 2'b00;
`ifdef EEP_WR_PROT_EN
            wr_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        last_gnt  <= win;
                        eep_addr  <= sel_addr;
                        eep_wdata <= sel_wdata;
                        busy      <= 1'b1;
`ifdef EEP_WR_PROT_EN
                        // Locked write: report and go straight to recovery.
                        if (sel_wr && !wr_unlock) begin
                            done[win] <= 1'b1;
                            wr_err    <= 1'b1;
                            cnt       <= CNT_W'(RECOV_CYCLES - 1);
                            state     <= RECOV;
                        end else
`endif
                        if (sel_wr) begin
                            eep_cs_n    <= 1'b0;
                            eep_r_w_n   <= 1'b0;
                            chrg_pmp_en <= 1'b1;
                            cnt         <= CNT_W'(CP_CYCLES - 1);
                            state       <= WR;
                        end else begin
                            eep_cs_n  <= 1'b0;
                            eep_r_w_n <= 1'b1;
                            cnt       <= CNT_W'(RD_CYCLES - 1);
                            state     <= RD;
                        end
                    end
                end
                RD: begin
                    if (cnt == '0) begin
                        rdata          <= eep_rd_data;
                        done[last_gnt] <= 1'b1;
                        eep_cs_n       <= 1'b1;
                        cnt            <= CNT_W'(RECOV_CYCLES - 1);
                        state          <= RECOV;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                WR: begin
                    if (cnt == '0) begin
                        done[last_gnt] <= 1'b1;
                        eep_cs_n       <= 1'b1;
                        eep_r_w_n      <= 1'b1;
                        chrg_pmp_en    <= 1'b0;
                        cnt            <= CNT_W'(RECOV_CYCLES - 1);
                        state          <= RECOV;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RECOV: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_eep_arb.sv
// ============================================================================
// tb_eep_arb : directed + randomized bench for eep_arb against a timeline model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_eep_arb;

    localparam int RD = 4;
    localparam int CP = 100;
    localparam int RC = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0, wr = '0, addr0 = '0, addr1 = '0;
    logic [13:0] wdata0 = '0, wdata1 = '0, eep_rd_data = '0;
    logic [1:0]  done;
    logic [13:0] rdata;
    logic        busy, eep_cs_n, eep_r_w_n, chrg_pmp_en;
    logic [1:0]  eep_addr;
    logic [13:0] eep_wdata;
`ifdef EEP_WR_PROT_EN
    logic        wr_unlock = 1'b1;
    logic        wr_err;
`endif

    eep_arb #(.RD_CYCLES(RD), .CP_CYCLES(CP), .RECOV_CYCLES(RC)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr(wr),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .eep_rd_data(eep_rd_data),
`ifdef EEP_WR_PROT_EN
        .wr_unlock(wr_unlock), .wr_err(wr_err),
`endif
        .done(done), .rdata(rdata), .busy(busy), .eep_cs_n(eep_cs_n),
        .eep_r_w_n(eep_r_w_n), .eep_addr(eep_addr), .eep_wdata(eep_wdata),
        .chrg_pmp_en(chrg_pmp_en)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Model: one transaction on a timeline. Interval k is the clock period
    // following rising edge k; a grant at edge g owns cs_n for intervals
    // g..g+len-1, pulses done at g+len and recovers until g+len+RC-1.
    int          cyc, g, len, next_free, who;
    bit          act, mw, blk, m_last;
    logic [1:0]  m_addr;
    logic [13:0] m_wd, m_rdata;
    logic        e_cs_n, e_rw, e_cp, e_busy, e_err;
    logic [1:0]  e_done;
    bit          hold = 0;
    bit [1:0]    just_done = '0;
    bit          prev_cs = 1, seen = 0;
    int          gap = 0;

    task automatic model_reset();
        cyc = 0; next_free = 1; act = 0; blk = 0; mw = 0; m_last = 1;
        g = 0; len = 0; who = 0;
        m_addr = '0; m_wd = '0; m_rdata = '0;
        prev_cs = 1; seen = 0; gap = 0;
    endtask

    task automatic model_edge();
        cyc++;
        if (act && !mw && !blk && cyc == g + RD) m_rdata = eep_rd_data;
        if (cyc >= next_free && req != 2'b00) begin
            if (req == 2'b11) who = m_last ? 0 : 1;
            else              who = req[1] ? 1 : 0;
            m_last = (who == 1);
            mw     = wr[who];
            m_addr = (who == 1) ? addr1 : addr0;
            m_wd   = (who == 1) ? wdata1 : wdata0;
`ifdef EEP_WR_PROT_EN
            blk = mw && !wr_unlock;
`else
            blk = 0;
`endif
            len       = blk ? 0 : (mw ? CP : RD);
            act       = 1;
            g         = cyc;
            next_free = g + len + RC + 1;
        end
    endtask

    task automatic model_expect();
        bit in_acc;
        in_acc = act && cyc >= g && cyc < g + len;
        e_cs_n = !in_acc;
        e_rw   = !(in_acc && mw);
        e_cp   = in_acc && mw;
        e_done = (act && cyc == g + len) ? ((who == 1) ? 2'b10 : 2'b01) : 2'b00;
        e_busy = act && cyc >= g && cyc < g + len + RC;
        e_err  = act && blk && cyc == g;
    endtask

    task automatic check_outputs(input string p);
        model_expect();
        check({p, "cs_n"},  eep_cs_n,    e_cs_n);
        check({p, "r_w_n"}, eep_r_w_n,   e_rw);
        check({p, "cp_en"}, chrg_pmp_en, e_cp);
        check({p, "done"},  done,        e_done);
        check({p, "busy"},  busy,        e_busy);
        check({p, "rdata"}, rdata,       m_rdata);
        check({p, "addr"},  eep_addr,    m_addr);
        check({p, "wdata"}, eep_wdata,   m_wd);
`ifdef EEP_WR_PROT_EN
        check({p, "wr_err"}, wr_err, e_err);
`endif
    endtask

    task automatic tick();
        model_edge();
        @(negedge clk);
        check_outputs("");
        check("done_excl", done != 2'b11, 1);
        if (eep_cs_n) gap++;
        else begin
            if (prev_cs && seen) check("cs_gap", gap >= RC + 1, 1);
            if (prev_cs) begin seen = 1; gap = 0; end
        end
        prev_cs = eep_cs_n;
        for (int i = 0; i < 2; i++) begin
            just_done[i] = e_done[i];
            if (e_done[i] && !hold) req[i] = 1'b0;
        end
    endtask

    int cnt_a, cnt_b, cnt_c, cnt_d;
    int order[$];
    int first;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("rst_");
        rst_n = 1'b1;

        // Single read from requester 0
        req = 2'b01; wr = 2'b00; addr0 = 2'd2; eep_rd_data = 14'h1ABC;
        cnt_a = 0; cnt_b = 0;
        repeat (20) begin tick(); cnt_a += !eep_cs_n; cnt_b += done[0]; end
        check("rd_cs_low", cnt_a, RD);
        check("rd_done0", cnt_b, 1);
        check("rd_rdata", rdata, 14'h1ABC);
        check("rd_idle", busy, 0);

        // Single write from requester 1
        req = 2'b10; wr = 2'b10; addr1 = 2'd3; wdata1 = 14'h0155; eep_rd_data = 14'h0777;
        cnt_a = 0; cnt_b = 0;
        repeat (120) begin tick(); cnt_a += chrg_pmp_en; cnt_b += done[1]; end
        check("wr_cp_len", cnt_a, CP);
        check("wr_done1", cnt_b, 1);
        check("wr_rdata_kept", rdata, 14'h1ABC);

        // Both requesters hold reads: grants must alternate
        hold = 1; req = 2'b11; wr = 2'b00; addr0 = 2'd0; addr1 = 2'd1;
        first = m_last ? 0 : 1;
        order.delete();
        repeat (60) begin tick(); if (done != 2'b00) order.push_back(int'(done[1])); end
        hold = 0; req = 2'b00;
        repeat (20) tick();
        check("alt_first_is_0", first, 0);
        check("alt_count", order.size() >= 4, 1);
        foreach (order[k]) check("alt_order", order[k], first ^ (k % 2));

        // Requester 0 drops req during RD
        req = 2'b01; wr = 2'b00; addr0 = 2'd3; eep_rd_data = 14'h0F0F;
        cnt_a = 0; cnt_b = 0;
        repeat (2) begin tick(); cnt_a += !eep_cs_n; cnt_b += done[0]; end
        req = 2'b00;
        repeat (20) begin tick(); cnt_a += !eep_cs_n; cnt_b += done[0]; end
        check("drop_cs_low", cnt_a, RD);
        check("drop_done0", cnt_b, 1);
        check("drop_busy", busy, 0);

        // Reset asserted mid-write
        req = 2'b01; wr = 2'b01; addr0 = 2'd1; wdata0 = 14'h2222;
        repeat (50) tick();
        check("prerst_cp", chrg_pmp_en, 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_mid_");
        req = 2'b00; wr = 2'b00;
        repeat (3) @(negedge clk);
        check_outputs("rst_hold_");
        rst_n = 1'b1;
        req = 2'b01; addr0 = 2'd1; eep_rd_data = 14'h2AAA;
        cnt_b = 0;
        repeat (20) begin tick(); cnt_b += done[0]; end
        check("post_rst_done0", cnt_b, 1);
        check("post_rst_rdata", rdata, 14'h2AAA);

`ifdef EEP_WR_PROT_EN
        wr_unlock = 1'b0;
        req = 2'b10; wr = 2'b10; addr1 = 2'd2; wdata1 = 14'h3FFF;
        cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
        repeat (15) begin
            tick();
            cnt_a += !eep_cs_n; cnt_b += chrg_pmp_en; cnt_c += wr_err;
            cnt_d += (wr_err && done == 2'b10);
        end
        check("prot_cs_low", cnt_a, 0);
        check("prot_cp", cnt_b, 0);
        check("prot_err", cnt_c, 1);
        check("prot_err_done", cnt_d, 1);
        wr_unlock = 1'b1;
        req = 2'b10; wr = 2'b10;
        cnt_b = 0; cnt_c = 0;
        repeat (120) begin tick(); cnt_b += chrg_pmp_en; cnt_c += wr_err; end
        check("unl_cp_len", cnt_b, CP);
        check("unl_err", cnt_c, 0);
`endif

        // Randomized traffic from both requesters
        repeat (500) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (!req[i] && !just_done[i] && $urandom_range(3) == 0) begin
                    req[i] = 1'b1;
                    wr[i]  = ($urandom_range(7) == 0);
                    if (i == 0) begin addr0 = 2'($urandom); wdata0 = 14'($urandom); end
                    else        begin addr1 = 2'($urandom); wdata1 = 14'($urandom); end
                end
            end
            eep_rd_data = 14'($urandom);
`ifdef EEP_WR_PROT_EN
            wr_unlock = ($urandom_range(3) != 0);
`endif
        end
        repeat (260) tick();
        check("drain_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
